// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB boundary: load-op encodings and
// legacy register-file constants.
package mem_wb_stage_pkg;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'b000,
    LOAD_LB   = 3'b001,
    LOAD_LH   = 3'b010,
    LOAD_LW   = 3'b011,
    LOAD_LBU  = 3'b100,
    LOAD_LHU  = 3'b101
  } load_op_e;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr  = 5'b00000;
  localparam int unsigned RegBus      = 32;
  localparam int unsigned RegAddrBus  = 5;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data extraction and extension plus misalignment detection.
// Purely combinational; also used by the MEM stage for store-mask checks.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        op_i,
  input  logic [1:0]        lo_i,
  output logic [DATA_W-1:0] data_o,
  output logic              mis_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = data_i[{lo_i, 3'b000} +: 8];
  assign half_v = data_i[{lo_i[1], 4'b0000} +: 16];

  // Extend the selected byte/half; unknown encodings pass the word through
  always_comb begin
    data_o = data_i;
    mis_o  = 1'b0;
    case (load_op_e'(op_i))
      LOAD_LB:  data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LOAD_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_v};
      LOAD_LH: begin
        data_o = {{(DATA_W-16){half_v[15]}}, half_v};
        mis_o  = lo_i[0];
      end
      LOAD_LHU: begin
        data_o = {{(DATA_W-16){1'b0}}, half_v};
        mis_o  = lo_i[0];
      end
      LOAD_LW:  mis_o = (lo_i != 2'b00);
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Write-back stage: aligns load data, buffers completed instructions in an
// out stage plus one skid entry, and commits one per non-stalled cycle.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wd,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [2:0]        in_load_op,
  input  logic [1:0]        in_addr_lo,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic              wd;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data;
    logic              mis;
  } entry_t;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  entry_t            in_e;
  entry_t            o_q, o_d, s_q, s_d;
  logic              o_valid_q, o_valid_d, s_valid_q, s_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, commit;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .data_i (in_wdata),
    .op_i   (in_load_op),
    .lo_i   (in_addr_lo),
    .data_o (ld_data),
    .mis_o  (ld_mis)
  );

  assign in_e     = '{wd: in_wd, waddr: in_waddr, data: ld_data, mis: ld_mis};
  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;
  // A flushed cycle never retires the out-stage entry
  assign commit   = o_valid_q && !stall && !flush;

  assign wb_we        = commit && o_q.wd && (o_q.waddr != '0) && !o_q.mis;
  assign wb_waddr     = o_valid_q ? o_q.waddr : '0;
  assign wb_wdata     = o_valid_q ? o_q.data  : '0;
  assign misalign_err = commit && o_q.mis;
  assign retire_cnt   = cnt_q;

  // Next-state for out stage, skid entry and retire counter in priority order
  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    cnt_d     = cnt_q;
    if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (commit && s_valid_q) begin
        o_d       = s_q;
        s_valid_d = 1'b0;
      end else if (accept && (!o_valid_q || commit)) begin
        o_d       = in_e;
        o_valid_d = 1'b1;
      end else if (accept && o_valid_q && stall) begin
        s_d       = in_e;
        s_valid_d = 1'b1;
      end else if (commit) begin
        o_valid_d = 1'b0;
      end
      if (commit) begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      o_q       <= '0;
      s_q       <= '0;
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      o_q       <= o_d;
      s_q       <= s_d;
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage with directed vectors.
module tb_mem_wb_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned EW     = 1 + ADDR_W + DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, in_wd, stall, flush;
  logic [ADDR_W-1:0] in_waddr;
  logic [DATA_W-1:0] in_wdata;
  logic [2:0]        in_load_op;
  logic [1:0]        in_addr_lo;
  logic              wb_we, misalign_err;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic [CNT_W-1:0]  retire_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_load_op(in_load_op), .in_addr_lo(in_addr_lo), .stall(stall),
    .flush(flush), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .misalign_err(misalign_err), .retire_cnt(retire_cnt)
  );

  logic [EW-1:0]    exp_q[$];
  int unsigned      n_checks = 0;
  int unsigned      n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] ev(input logic we, input logic [ADDR_W-1:0] a,
                                       input logic [DATA_W-1:0] d, input logic mis);
    return {we, a, d, mis};
  endfunction

  task automatic idle();
    in_valid = 1'b0; in_wd = 1'b0; in_waddr = '0; in_wdata = '0;
    in_load_op = 3'b000; in_addr_lo = 2'b00;
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction; push its expected commit when it will be accepted
  task automatic send(input logic wd, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] d,
                      input logic [2:0] op, input logic [1:0] lo, input logic [EW-1:0] e);
    int unsigned waits = 0;
    in_valid = 1'b1; in_wd = wd; in_waddr = wa; in_wdata = d;
    in_load_op = op; in_addr_lo = lo;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        break;
      end
      waits++;
      if (waits > 50) begin
        n_checks++;
        $display("FAIL send_timeout: in_ready stuck at %0b required 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: a retire_cnt step marks that last cycle's outputs were a commit
  logic [CNT_W-1:0] prev_cnt = '0;
  logic [CNT_W-1:0] nxt_cnt;
  logic [EW-1:0]    snap_vec = '0;
  logic             snap_rst = 1'b1;
  logic [EW-1:0]    exp_v;
  always @(negedge clk) begin
    nxt_cnt = prev_cnt + 1'b1;
    if (rst || snap_rst) begin
    end else if (retire_cnt != prev_cnt) begin
      chk("cnt_step", 64'(retire_cnt), 64'(nxt_cnt));
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL commit_unexpected: got %0h required none", snap_vec);
      end else begin
        exp_v = exp_q.pop_front();
        chk("commit", 64'(snap_vec), 64'(exp_v));
      end
    end else if (snap_vec[EW-1] || snap_vec[0]) begin
      n_checks++;
      $display("FAIL spurious_write: we/mis=%0b%0b without commit, required 00",
               snap_vec[EW-1], snap_vec[0]);
    end
    prev_cnt = retire_cnt;
    snap_rst = rst;
    snap_vec = {wb_we, wb_waddr, wb_wdata, misalign_err};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_we", 64'(wb_we), 64'(0));
    chk("rst_waddr", 64'(wb_waddr), 64'(0));
    chk("rst_wdata", 64'(wb_wdata), 64'(0));
    chk("rst_mis", 64'(misalign_err), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_cnt", 64'(retire_cnt), 64'(0));
    @(posedge clk); #1;

    // Back-to-back ALU writes
    send(1'b1, 5'd3, 32'd5, 3'b000, 2'd0, ev(1'b1, 5'd3, 32'd5, 1'b0));
    send(1'b1, 5'd4, 32'd7, 3'b000, 2'd0, ev(1'b1, 5'd4, 32'd7, 1'b0));
    idle();
    @(negedge clk);
    chk("latency_we_addr", 64'({wb_we, wb_waddr}), 64'({1'b1, 5'd4}));
    wait_cycles(1);
    @(negedge clk);
    chk("cnt_after_alu", 64'(retire_cnt), 64'(2));
    wait_cycles(1);

    // Load extension
    send(1'b1, 5'd6,  32'h80FF_1234, 3'b001, 2'd3, ev(1'b1, 5'd6,  32'hFFFF_FF80, 1'b0));
    send(1'b1, 5'd7,  32'h80FF_1234, 3'b100, 2'd3, ev(1'b1, 5'd7,  32'h0000_0080, 1'b0));
    send(1'b1, 5'd8,  32'h80FF_1234, 3'b010, 2'd2, ev(1'b1, 5'd8,  32'hFFFF_80FF, 1'b0));
    send(1'b1, 5'd9,  32'h80FF_1234, 3'b101, 2'd0, ev(1'b1, 5'd9,  32'h0000_1234, 1'b0));
    send(1'b1, 5'd10, 32'h80FF_1234, 3'b001, 2'd1, ev(1'b1, 5'd10, 32'h0000_0012, 1'b0));
    send(1'b1, 5'd11, 32'h80FF_1234, 3'b110, 2'd1, ev(1'b1, 5'd11, 32'h80FF_1234, 1'b0));
    idle();
    wait_cycles(2);
    @(negedge clk);
    chk("cnt_after_loads", 64'(retire_cnt), 64'(8));
    wait_cycles(1);

    // Misaligned LW
    send(1'b1, 5'd5, 32'h80FF_1234, 3'b011, 2'd2, ev(1'b0, 5'd5, 32'h80FF_1234, 1'b1));
    idle();
    wait_cycles(2);
    @(negedge clk);
    chk("cnt_after_mis", 64'(retire_cnt), 64'(9));
    wait_cycles(1);

    // Stall for 3 cycles with 3 instructions offered
    fork
      begin
        send(1'b1, 5'd12, 32'hA, 3'b000, 2'd0, ev(1'b1, 5'd12, 32'hA, 1'b0));
        send(1'b1, 5'd13, 32'hB, 3'b000, 2'd0, ev(1'b1, 5'd13, 32'hB, 1'b0));
        send(1'b1, 5'd14, 32'hC, 3'b000, 2'd0, ev(1'b1, 5'd14, 32'hC, 1'b0));
      end
      begin
        stall = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_ready_low", 64'(in_ready), 64'(0));
        chk("stall_no_we", 64'(wb_we), 64'(0));
        @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    idle();
    wait_cycles(3);
    @(negedge clk);
    chk("cnt_after_stall", 64'(retire_cnt), 64'(12));
    wait_cycles(1);

    // Flush with O and S full, input offered, stall held
    stall = 1'b1;
    send(1'b1, 5'd15, 32'h111, 3'b000, 2'd0, ev(1'b1, 5'd15, 32'h111, 1'b0));
    send(1'b1, 5'd16, 32'h222, 3'b000, 2'd0, ev(1'b1, 5'd16, 32'h222, 1'b0));
    in_valid = 1'b1; in_wd = 1'b1; in_waddr = 5'd17; in_wdata = 32'h333;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; stall = 1'b0;
    idle();
    exp_q.delete();
    wait_cycles(3);
    @(negedge clk);
    chk("flush_full_cnt", 64'(retire_cnt), 64'(12));
    chk("flush_full_ready", 64'(in_ready), 64'(1));
    wait_cycles(1);

    // Flush drops a same-cycle accept
    stall = 1'b1;
    send(1'b1, 5'd18, 32'h444, 3'b000, 2'd0, ev(1'b1, 5'd18, 32'h444, 1'b0));
    in_valid = 1'b1; in_wd = 1'b1; in_waddr = 5'd19; in_wdata = 32'h555;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; stall = 1'b0;
    idle();
    exp_q.delete();
    wait_cycles(3);
    @(negedge clk);
    chk("flush_accept_cnt", 64'(retire_cnt), 64'(12));
    wait_cycles(1);

    // Write to x0
    send(1'b1, 5'd0, 32'h55, 3'b000, 2'd0, ev(1'b0, 5'd0, 32'h55, 1'b0));
    idle();
    wait_cycles(2);
    @(negedge clk);
    chk("cnt_after_x0", 64'(retire_cnt), 64'(13));
    wait_cycles(1);

    // Reset mid-stall
    stall = 1'b1;
    send(1'b1, 5'd20, 32'h666, 3'b000, 2'd0, ev(1'b1, 5'd20, 32'h666, 1'b0));
    send(1'b1, 5'd21, 32'h777, 3'b000, 2'd0, ev(1'b1, 5'd21, 32'h777, 1'b0));
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst2_outputs", 64'({wb_we, wb_waddr, wb_wdata, misalign_err}), 64'(0));
    chk("rst2_ready", 64'(in_ready), 64'(1));
    chk("rst2_cnt", 64'(retire_cnt), 64'(0));
    @(posedge clk);
    #1 stall = 1'b0;
    wait_cycles(2);
    @(negedge clk);
    chk("rst2_no_late_commit", 64'(retire_cnt), 64'(0));
    wait_cycles(1);

    // Drive the counter to its maximum then wrap it
    for (int i = 1; i < 256; i++) begin
      send(1'b1, 5'd1, 32'(i), 3'b000, 2'd0, ev(1'b1, 5'd1, 32'(i), 1'b0));
    end
    idle();
    wait_cycles(2);
    @(negedge clk);
    chk("cnt_max", 64'(retire_cnt), 64'(8'hFF));
    wait_cycles(1);
    send(1'b1, 5'd0, 32'hAB, 3'b000, 2'd0, ev(1'b0, 5'd0, 32'hAB, 1'b0));
    idle();
    wait_cycles(2);
    @(negedge clk);
    chk("cnt_wrap", 64'(retire_cnt), 64'(0));

    wait_cycles(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
